// File: rtl/sha2_pkg.sv
// Shared SHA-2 constants, FSM encodings and sigma helpers for the compression controller.
// Mode 0 is SHA-256 (32-bit words held in the low half), mode 1 is SHA-384/512 (64-bit words).
package sha2_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUND = 2'd1;
    localparam logic [1:0] ST_FINAL = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int unsigned ROUNDS_256 = 64;
    localparam int unsigned ROUNDS_512 = 80;

    localparam logic [511:0] IV256 = {
        32'h0, 32'h6a09e667, 32'h0, 32'hbb67ae85, 32'h0, 32'h3c6ef372, 32'h0, 32'ha54ff53a,
        32'h0, 32'h510e527f, 32'h0, 32'h9b05688c, 32'h0, 32'h1f83d9ab, 32'h0, 32'h5be0cd19
    };

    localparam logic [511:0] IV512 = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };

    function automatic logic [63:0] word_mask(input logic mode);
        return mode ? 64'hffff_ffff_ffff_ffff : 64'h0000_0000_ffff_ffff;
    endfunction

    // In mode 0 only the low 32 bits rotate; the upper half is returned as zero.
    function automatic logic [63:0] rotr(input logic mode, input logic [63:0] x, input int unsigned n);
        logic [31:0] lo;
        lo = x[31:0];
        if (mode)
            return (x >> n) | (x << (64 - n));
        return {32'h0, (lo >> n) | (lo << (32 - n))};
    endfunction

    function automatic logic [63:0] big_sigma0(input logic mode, input logic [63:0] x);
        if (mode)
            return rotr(1'b1, x, 28) ^ rotr(1'b1, x, 34) ^ rotr(1'b1, x, 39);
        return rotr(1'b0, x, 2) ^ rotr(1'b0, x, 13) ^ rotr(1'b0, x, 22);
    endfunction

    function automatic logic [63:0] big_sigma1(input logic mode, input logic [63:0] x);
        if (mode)
            return rotr(1'b1, x, 14) ^ rotr(1'b1, x, 18) ^ rotr(1'b1, x, 41);
        return rotr(1'b0, x, 6) ^ rotr(1'b0, x, 11) ^ rotr(1'b0, x, 25);
    endfunction

    function automatic logic [63:0] small_sigma0(input logic mode, input logic [63:0] x);
        logic [31:0] lo;
        lo = x[31:0];
        if (mode)
            return rotr(1'b1, x, 1) ^ rotr(1'b1, x, 8) ^ (x >> 7);
        return rotr(1'b0, x, 7) ^ rotr(1'b0, x, 18) ^ {32'h0, lo >> 3};
    endfunction

    function automatic logic [63:0] small_sigma1(input logic mode, input logic [63:0] x);
        logic [31:0] lo;
        lo = x[31:0];
        if (mode)
            return rotr(1'b1, x, 19) ^ rotr(1'b1, x, 61) ^ (x >> 6);
        return rotr(1'b0, x, 17) ^ rotr(1'b0, x, 19) ^ {32'h0, lo >> 10};
    endfunction

endpackage

// File: rtl/sha2_msg_sched.sv
// 16-word message schedule window; win[15] is W(t-1), win[0] is W(t-16).
// load_sel passes the external word through for t<16, otherwise the expansion is used.
module sha2_msg_sched
    import sha2_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mode,
    input  logic        shift_en,
    input  logic        load_sel,
    input  logic [63:0] w_in,
    output logic [63:0] w_t
);

    logic [63:0] win [16];
    logic [63:0] mask;
    logic [63:0] expand;

    always_comb begin
        mask   = word_mask(mode);
        expand = (small_sigma1(mode, win[14]) + win[9] + small_sigma0(mode, win[1]) + win[0]) & mask;
        w_t    = load_sel ? (w_in & mask) : expand;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 16; i++)
                win[i] <= '0;
        end else if (shift_en) begin
            for (int unsigned i = 0; i < 15; i++)
                win[i] <= win[i + 1];
            win[15] <= w_t;
        end
    end

endmodule

// File: rtl/sha2_round.sv
// One combinational SHA-2 round: working variables a..h packed a-first in 512 bits.
// Inputs are assumed already masked to the active word width.
module sha2_round
    import sha2_pkg::*;
(
    input  logic         mode,
    input  logic [511:0] state_in,
    input  logic [63:0]  k,
    input  logic [63:0]  w,
    output logic [511:0] state_out
);

    logic [63:0] a, b, c, d, e, f, g, h;
    logic [63:0] t1, t2, mask;

    always_comb begin
        {a, b, c, d, e, f, g, h} = state_in;
        mask = word_mask(mode);
        t1 = h + big_sigma1(mode, e) + ((e & f) ^ (~e & g)) + k + w;
        t2 = big_sigma0(mode, a) + ((a & b) ^ (a & c) ^ (b & c));
        state_out = {(t1 + t2) & mask, a, b, c, (d + t1) & mask, e, f, g};
    end

endmodule

// File: rtl/sha2_compress_ctrl.sv
// SHA-2 compression sequencer: loads H, runs 64/80 rounds with stall-able word input,
// then adds the working variables back into H and pulses done for one cycle.
module sha2_compress_ctrl
    import sha2_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         mode_sha2,
    input  logic [511:0] h_in,
    input  logic         w_valid,
    output logic         w_ready,
    input  logic [63:0]  w_data,
    output logic [6:0]   k_addr,
    input  logic [31:0]  k_256,
    input  logic [63:0]  k_512,
    output logic         busy,
    output logic         done,
    output logic [511:0] h_out
);

    logic [1:0]   state;
    logic [6:0]   t;
    logic         mode_r;
    logic [511:0] hreg;
    logic [511:0] work;
    logic [511:0] round_out;
    logic [511:0] h_sum;
    logic [511:0] h_load;
    logic [63:0]  k_cur;
    logic [63:0]  w_t;
    logic         in_round;
    logic         early;
    logic         fire;
    logic         last;

    always_comb begin
        in_round = (state == ST_ROUND);
        early    = (t < 7'd16);
        w_ready  = in_round && early;
        // Rounds beyond the first 16 never wait: their word comes from the schedule.
        fire     = in_round && (!early || w_valid);
        last     = mode_r ? (t == 7'(ROUNDS_512 - 1)) : (t == 7'(ROUNDS_256 - 1));
        k_addr   = in_round ? t : '0;
        k_cur    = mode_r ? k_512 : {32'h0, k_256};
        busy     = in_round || (state == ST_FINAL);
        done     = (state == ST_DONE);
        h_load   = '0;
        h_sum    = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            h_load[64*i +: 64] = h_in[64*i +: 64] & word_mask(mode_sha2);
            h_sum[64*i +: 64]  = (hreg[64*i +: 64] + work[64*i +: 64]) & word_mask(mode_r);
        end
    end

    sha2_msg_sched u_sched (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode_r),
        .shift_en (fire),
        .load_sel (early),
        .w_in     (w_data),
        .w_t      (w_t)
    );

    sha2_round u_round (
        .mode      (mode_r),
        .state_in  (work),
        .k         (k_cur),
        .w         (w_t),
        .state_out (round_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            t      <= '0;
            mode_r <= 1'b0;
            hreg   <= '0;
            work   <= '0;
            h_out  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_r <= mode_sha2;
                        hreg   <= h_load;
                        work   <= h_load;
                        t      <= '0;
                        state  <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    if (fire) begin
                        work <= round_out;
                        t    <= t + 7'd1;
                        if (last)
                            state <= ST_FINAL;
                    end
                end
                ST_FINAL: begin
                    hreg  <= h_sum;
                    h_out <= h_sum;
                    state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
